mips_datapath: RTL



---
 rtl/mips_datapath.sv | 114 +++++++++++
 1 files changed

// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, 32x32 register file and unified memory port.
// Optional MIPS_DP_ZEROEXT_EN adds the ExtOp port for zero-extended immediates (ANDI/ORI/XORI).
module mips_datapath (
  input  logic        clk,
  input  logic        rstb,
  input  logic        IorD,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic [1:0]  PCSrc,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [3:0]  ALUControl,
`ifdef MIPS_DP_ZEROEXT_EN
  input  logic        ExtOp,
`endif
  input  logic [31:0] mem_rdata,
  output logic [31:0] Instr,
  output logic        Zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  logic [31:0] pc, ir, mdr, reg_a, reg_b, alu_out;
  logic [31:0] rf [32];
  logic [31:0] rd1, rd2, ext_imm, src_a, src_b, alu_result, pc_next, wdata;
  logic [4:0]  waddr;
  logic        pc_en;

  // Register 0 is hardwired to zero on the read side; writes to it are also dropped.
  assign rd1 = (ir[25:21] == 5'd0) ? 32'd0 : rf[ir[25:21]];
  assign rd2 = (ir[20:16] == 5'd0) ? 32'd0 : rf[ir[20:16]];

`ifdef MIPS_DP_ZEROEXT_EN
  assign ext_imm = ExtOp ? {16'd0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
`else
  assign ext_imm = {{16{ir[15]}}, ir[15:0]};
`endif

  assign src_a = ALUSrcA ? reg_a : pc;

  always_comb begin
    src_b = reg_b;
    case (ALUSrcB)
      2'b00: src_b = reg_b;
      2'b01: src_b = 32'd4;
      2'b10: src_b = ext_imm;
      2'b11: src_b = {ext_imm[29:0], 2'b00};
      default: src_b = reg_b;
    endcase
  end

  always_comb begin
    alu_result = 32'd0;
    case (ALUControl)
      4'b0000: alu_result = src_a & src_b;
      4'b0001: alu_result = src_a | src_b;
      4'b0010: alu_result = src_a + src_b;
      4'b0011: alu_result = src_a ^ src_b;
      4'b0110: alu_result = src_a - src_b;
      4'b0111: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      4'b1100: alu_result = ~(src_a | src_b);
      default: alu_result = 32'd0;
    endcase
  end

  assign Zero = (alu_result == 32'd0);

  always_comb begin
    pc_next = pc;
    case (PCSrc)
      2'b00: pc_next = alu_result;
      2'b01: pc_next = alu_out;
      2'b10: pc_next = {pc[31:28], ir[25:0], 2'b00};
      2'b11: pc_next = pc;
      default: pc_next = pc;
    endcase
  end

  assign pc_en     = PCWrite | (Branch & Zero);
  assign waddr     = RegDst ? ir[15:11] : ir[20:16];
  assign wdata     = MemtoReg ? mdr : alu_out;
  assign Instr     = ir;
  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = reg_b;
  assign mem_we    = MemWrite;

  // Reset wins over every enable, so an instruction caught mid-flight leaves no trace.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      pc      <= 32'd0;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      reg_a   <= 32'd0;
      reg_b   <= 32'd0;
      alu_out <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (pc_en) pc <= pc_next;
      if (IRWrite) ir <= mem_rdata;
      mdr     <= mem_rdata;
      reg_a   <= rd1;
      reg_b   <= rd2;
      alu_out <= alu_result;
      if (RegWrite && waddr != 5'd0) rf[waddr] <= wdata;
    end
  end

endmodule
